pdm_playback_seq: RTL

//  Sequencer for the file-backed PDM stimulus ROM used by the mic-array testbench.
//  - Generates the emulated mic PDM clock and steps the ROM index once per PDM period.
//  - Registers each ROM word onto the CHANNELS-wide PDM data bus.
//  - Supports single-shot or looped playback, abort and end-of-file signalling.
//  - Sits between the stimulus ROM and the mic-array front end (decimator input).

---
 rtl/pdm_playback_seq_pkg.sv | 15 +
 rtl/pdm_playback_seq_clk_gen.sv | 56 +++++
 rtl/pdm_playback_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pdm_playback_seq_pkg.sv
// Shared constants for the PDM playback sequencer: index width and FSM encodings.
package pdm_playback_seq_pkg;

  localparam int unsigned IDX_W = 15;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Index of the final ROM word for a given ROM depth.
  function automatic logic [IDX_W-1:0] last_index(input int unsigned depth);
    return IDX_W'(depth - 1);
  endfunction

endpackage

// File: rtl/pdm_playback_seq_clk_gen.sv
// PDM clock divider: period counter, 50% duty emulated mic clock and period tick.
module pdm_playback_seq_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic clr_i,
  input  logic load_i,
  output logic pdm_clk_o,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pclk_q, pclk_d;

  // Tick marks the edge on which the counter wraps back to zero.
  assign tick_c_o  = en_i & (cnt_q == CNT_LAST);
  assign pdm_clk_o = pclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    pclk_d = pclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      pclk_d = 1'b0;
    end else if (load_i) begin
      // Preload so the first tick lands on the very next edge.
      cnt_d  = CNT_LAST;
      pclk_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        pclk_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_FALL) pclk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

endmodule

// File: rtl/pdm_playback_seq.sv
// Steps the stimulus ROM once per PDM period and registers each word onto the mic bus.
module pdm_playback_seq
  import pdm_playback_seq_pkg::*;
#(
  parameter int unsigned CHANNELS  = 8,
  parameter int unsigned NLINEFILE = 16384,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [CHANNELS-1:0] rom_data,
  output logic [IDX_W-1:0]    indx,
  output logic                pdm_clk,
  output logic [CHANNELS-1:0] pdm_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_W-1:0] LAST_IDX = last_index(NLINEFILE);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    indx_q, indx_d;
  logic [CHANNELS-1:0] pout_q, pout_d;
  logic                sample_valid_q, sample_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic gen_en_c, gen_clr_c, gen_load_c, tick_c;

  pdm_playback_seq_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .resetn    (resetn),
    .en_i      (gen_en_c),
    .clr_i     (gen_clr_c),
    .load_i    (gen_load_c),
    .pdm_clk_o (pdm_clk),
    .tick_c_o  (tick_c)
  );

  always_comb begin
    state_d        = state_q;
    indx_d         = indx_q;
    pout_d         = pout_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    gen_en_c       = 1'b0;
    gen_clr_c      = 1'b0;
    gen_load_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_RUN;
          indx_d     = '0;
          gen_load_c = 1'b1;
        end
      end
      ST_RUN: begin
        gen_en_c = 1'b1;
        // Abort outranks a coincident tick.
        if (stop) begin
          state_d   = ST_IDLE;
          indx_d    = '0;
          pout_d    = '0;
          gen_clr_c = 1'b1;
        end else if (tick_c) begin
          pout_d         = rom_data;
          sample_valid_d = 1'b1;
          if (indx_q != LAST_IDX) begin
            indx_d = indx_q + IDX_W'(1);
          end else if (loop_en) begin
            indx_d = '0;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        gen_en_c = 1'b1;
        if (stop) begin
          state_d   = ST_IDLE;
          indx_d    = '0;
          pout_d    = '0;
          gen_clr_c = 1'b1;
        end else if (tick_c) begin
          state_d   = ST_IDLE;
          indx_d    = '0;
          pout_d    = '0;
          done_d    = 1'b1;
          gen_clr_c = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        indx_d    = '0;
        pout_d    = '0;
        gen_clr_c = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      indx_q         <= '0;
      pout_q         <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      indx_q         <= indx_d;
      pout_q         <= pout_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign indx         = indx_q;
  assign pdm_out      = pout_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
